// File: rtl/timedisk_pkg.sv
// Shared definitions for the TimeDisk bus timing logic.
// Bus-phase state encodings, the phase type and a saturating counter step.
package timedisk_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t S_IDLE     = 3'd0;
    localparam phase_t S_SYNC     = 3'd1;
    localparam phase_t S_DRVFIRST = 3'd4;
    localparam phase_t S_LAST     = 3'd7;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/phi_edge_sync.sv
// PHI1 phase sampler: two flops on the falling C7M edge plus sync-event decode.
// Ports: clk (C7M), rst (async, high), phi1 (bus PHI1), se (sync event, PHI1 rise).
module phi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic phi1,
    output logic se
);

    logic [1:0] ph;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) ph <= 2'b00;
        else     ph <= {ph[0], ~phi1};
    end

    // PHI1 was low two samples ago, high at the last sample and still high now
    assign se = ph[1] & ~ph[0] & phi1;

endmodule

// File: rtl/bus_phase_seq.sv
// Apple II bus phase recovery: S counter, drive window, bus reset sync,
// cycle-length measurement and PHI1 loss watchdog.
// Ports: C7M, RES (async high), PHI1, nRES in; S, SyncPls, nRESr, ClrPls,
// CSDBEN, CycLen, LongCyc, ClkLost out (all registered).
module bus_phase_seq
    import timedisk_pkg::*;
#(
    parameter int LOSS_TIMEOUT = 32,
    parameter int CYC_NORM     = 14,
    parameter int CYC_LONG     = 16
) (
    input  logic       C7M,
    input  logic       RES,
    input  logic       PHI1,
    input  logic       nRES,
    output logic [2:0] S,
    output logic       SyncPls,
    output logic       nRESr,
    output logic       ClrPls,
    output logic       CSDBEN,
    output logic [4:0] CycLen,
    output logic       LongCyc,
    output logic       ClkLost
);

    if (CYC_LONG <= CYC_NORM || LOSS_TIMEOUT < 16 || LOSS_TIMEOUT > 63)
    begin : g_bad_param
        $error("bus_phase_seq: parameter out of range");
    end

    localparam logic [5:0] W_LAST   = 6'(LOSS_TIMEOUT - 1);
    localparam logic [5:0] LONG_LEN = 6'(CYC_LONG);

    logic       se;
    logic       r0;
    logic [4:0] len;
    logic [5:0] wd;

    phase_t     s_nxt;
    logic       nresr_nxt, clr_nxt, cs_nxt, long_nxt, lost_nxt;
    logic [4:0] cyc_nxt, len_nxt;
    logic [5:0] wd_nxt;
    logic [5:0] len_inc;

    phi_edge_sync u_sync (
        .clk  (C7M),
        .rst  (RES),
        .phi1 (PHI1),
        .se   (se)
    );

    assign len_inc = {1'b0, len} + 6'd1;

    always_comb begin
        s_nxt     = S;
        nresr_nxt = nRESr & r0;
        clr_nxt   = 1'b0;
        cs_nxt    = (S >= S_DRVFIRST) & ~ClkLost;
        cyc_nxt   = CycLen;
        long_nxt  = LongCyc;
        len_nxt   = sat_inc5(len);
        wd_nxt    = wd;
        lost_nxt  = ClkLost;

        if (se)                 s_nxt = S_SYNC;
        else if (ClkLost)       s_nxt = S_IDLE;
        else if (S == S_IDLE)   s_nxt = S_IDLE;
        else if (S == S_LAST)   s_nxt = S_LAST;
        else                    s_nxt = S + 3'd1;

        // Bus reset may only be released at the start of a cycle
        if (S == S_SYNC) begin
            nresr_nxt = r0;
            clr_nxt   = ~nRESr;
        end

        if (se) begin
            cyc_nxt  = len_inc[5] ? 5'd31 : len_inc[4:0];
            long_nxt = (len_inc == LONG_LEN);
            len_nxt  = 5'd0;
        end

        // A sync event beats a simultaneous watchdog expiry
        if (se) begin
            wd_nxt   = 6'd0;
            lost_nxt = 1'b0;
        end else if (wd == W_LAST) begin
            lost_nxt = 1'b1;
        end else begin
            wd_nxt = wd + 6'd1;
        end
    end

    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            S       <= S_IDLE;
            SyncPls <= 1'b0;
            r0      <= 1'b0;
            nRESr   <= 1'b0;
            ClrPls  <= 1'b0;
            CSDBEN  <= 1'b0;
            CycLen  <= 5'd0;
            LongCyc <= 1'b0;
            len     <= 5'd0;
            wd      <= 6'd0;
            ClkLost <= 1'b0;
        end else begin
            S       <= s_nxt;
            SyncPls <= se;
            r0      <= nRES;
            nRESr   <= nresr_nxt;
            ClrPls  <= clr_nxt;
            CSDBEN  <= cs_nxt;
            CycLen  <= cyc_nxt;
            LongCyc <= long_nxt;
            len     <= len_nxt;
            wd      <= wd_nxt;
            ClkLost <= lost_nxt;
        end
    end

endmodule
